program_counter: RTL and testbench

- Program counter register for the processor's instruction-fetch stage.
- Each clock it either advances sequentially by a fixed increment or loads an absolute branch target supplied by the control/branch logic.
- Its output `progCtr` drives the instruction memory address.

---
 rtl/program_counter.sv | 61 ++++++
 tb/tb_program_counter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// Program counter for the instruction-fetch stage.
// Each rising edge either loads an absolute branch target or advances by a
// fixed increment. The increment wraps modulo 2^PC_WIDTH. An active-low
// asynchronous reset forces the counter to RESET_VECTOR.
module program_counter #(
  parameter int unsigned PC_WIDTH     = 8,
  parameter int unsigned RESET_VECTOR = 0,
  parameter int unsigned INCREMENT    = 1
) (
  input  logic                clk,
  input  logic                reset,    // active-low, asynchronous
  input  logic                branch,
  input  logic [PC_WIDTH-1:0] target,
  output logic [PC_WIDTH-1:0] progCtr
);

  // Number of distinct addresses. It is held in 64 bits so the range checks
  // below stay exact even when PC_WIDTH is 32.
  localparam longint unsigned PC_RANGE = 64'd1 << PC_WIDTH;

  // Reject parameter sets that cannot be represented in the counter.
  if (PC_WIDTH == 0 || PC_WIDTH > 32) begin : g_bad_width
    $error("program_counter: PC_WIDTH must be between 1 and 32");
  end
  if (longint'(RESET_VECTOR) >= PC_RANGE) begin : g_bad_reset_vector
    $error("program_counter: RESET_VECTOR does not fit in PC_WIDTH bits");
  end
  if (INCREMENT == 0 || longint'(INCREMENT) >= PC_RANGE) begin : g_bad_increment
    $error("program_counter: INCREMENT must be in 1 .. 2^PC_WIDTH-1");
  end

  localparam logic [PC_WIDTH-1:0] RST_VAL = PC_WIDTH'(RESET_VECTOR);
  localparam logic [PC_WIDTH-1:0] INC_VAL = PC_WIDTH'(INCREMENT);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;

  // Next address: a branch overrides the sequential step. The sum is
  // truncated to PC_WIDTH bits, so wrap-around needs no extra logic.
  always_comb begin
    // NOTE: assign a default first, so that every path writes pc_d and no latch is inferred.
    pc_d = pc_q + INC_VAL;
    if (branch) begin
      pc_d = target;
    end
  end

  // PC register. Reset takes effect at once and holds while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: use non-blocking (<=) for all clocked state, so every register sees pre-edge values.
    if (!reset) begin
      pc_q <= RST_VAL;
    end else begin
      pc_q <= pc_d;
    end
  end

  // The output comes straight from the register, so it has no combinational path from the inputs.
  assign progCtr = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter.
// It runs two instances: the default configuration (A: 8 bits, increment 1)
// and a narrow one (B: 4 bits, increment 2). An arithmetic model tracks the
// expected address of each instance. Directed sequences pin the model to
// hand-computed values. Random branch, target and reset traffic then
// exercises the design against the model.
module tb_program_counter;

  localparam int A_W   = 8;
  localparam int A_INC = 1;
  localparam int B_W   = 4;
  localparam int B_INC = 2;
  localparam int RV    = 0;

  logic           clk;
  logic           reset;
  logic           branch_a;
  logic [A_W-1:0] target_a;
  logic [A_W-1:0] pc_a;
  logic           branch_b;
  logic [B_W-1:0] target_b;
  logic [B_W-1:0] pc_b;

  int tests_run;
  int tests_failed;

  // Model state. Values stay meaningful only after the model has seen a reset.
  int exp_a;
  int exp_b;
  bit model_valid;

  program_counter #(
    .PC_WIDTH    (A_W),
    .RESET_VECTOR(RV),
    .INCREMENT   (A_INC)
  ) u_dut_a (
    .clk    (clk),
    .reset  (reset),
    .branch (branch_a),
    .target (target_a),
    .progCtr(pc_a)
  );

  program_counter #(
    .PC_WIDTH    (B_W),
    .RESET_VECTOR(RV),
    .INCREMENT   (B_INC)
  ) u_dut_b (
    .clk    (clk),
    .reset  (reset),
    .branch (branch_b),
    .target (target_b),
    .progCtr(pc_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model and compare process. Inputs change only on falling
  // edges, so they are stable when sampled at the rising edge. The outputs
  // are compared 1 ns after that edge.
  always begin
    @(posedge clk);
    if (!reset) begin
      exp_a = RV;
      exp_b = RV;
      model_valid = 1'b1;
    end else if (model_valid) begin
      exp_a = branch_a ? int'(target_a) : (exp_a + A_INC) % (1 << A_W);
      exp_b = branch_b ? int'(target_b) : (exp_b + B_INC) % (1 << B_W);
    end
    #1;
    if (model_valid) begin
      check("model_a", int'(pc_a), exp_a);
      check("model_b", int'(pc_b), exp_b);
    end
  end

  // Drive one edge on instance A while B increments. Then check A against a
  // hand-computed value, and check the model against the same value.
  task automatic step_a(input logic br, input int tg, input int want, input string name);
    branch_a = br;
    target_a = A_W'(tg);
    @(negedge clk);
    check(name, int'(pc_a), want);
    check({name, "_ref"}, exp_a, want);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0t expected < 1000000", $time);
    $fatal(1);
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    model_valid  = 1'b0;
    exp_a        = 0;
    exp_b        = 0;
    reset        = 1'b0;
    branch_a     = 1'b0;
    target_a     = '0;
    branch_b     = 1'b0;
    target_b     = '0;

    // Reset hold: the counter stays at 0 for 6 cycles, even with a branch requested.
    for (int i = 0; i < 6; i++) begin
      branch_a = (i >= 4);
      target_a = 8'd99;
      @(negedge clk);
      check("reset_hold", int'(pc_a), 0);
    end

    // Sequential count after reset is released.
    reset = 1'b1;
    for (int i = 1; i <= 5; i++) step_a(1'b0, 0, i, "seq_count");

    // Branch load, held for two edges, then counting resumes.
    step_a(1'b1, 45, 45, "branch45_1");
    step_a(1'b1, 45, 45, "branch45_2");
    step_a(1'b0, 0, 46, "after45_1");
    step_a(1'b0, 0, 47, "after45_2");

    // Second branch, held for five edges.
    for (int i = 0; i < 5; i++) step_a(1'b1, 127, 127, "branch127");
    for (int i = 128; i <= 133; i++) step_a(1'b0, 0, i, "after127");

    // Reset asserted between edges: the output must drop at once, then hold.
    #2 reset = 1'b0;
    #1;
    check("async_reset_a", int'(pc_a), 0);
    check("async_reset_b", int'(pc_b), 0);
    @(negedge clk);
    check("reset_held", int'(pc_a), 0);
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) step_a(1'b0, 0, i, "after_reset");

    // Wrap on A (254 -> 255 -> 0 -> 1), and on B (14 -> 0 -> 2) in parallel.
    branch_b = 1'b1;
    target_b = 4'd14;
    step_a(1'b1, 254, 254, "wrap_branch");
    check("b_branch14", int'(pc_b), 14);
    branch_b = 1'b0;
    step_a(1'b0, 0, 255, "wrap_255");
    check("b_wrap0", int'(pc_b), 0);
    step_a(1'b0, 0, 0, "wrap_0");
    check("b_wrap2", int'(pc_b), 2);
    step_a(1'b0, 0, 1, "wrap_1");

    // A branch to the current value leaves the counter unchanged.
    step_a(1'b1, 1, 1, "branch_self");
    step_a(1'b0, 0, 2, "after_self");

    // Random traffic. The model process does the checking; mid-cycle resets
    // are also checked directly for their immediate effect.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        branch_a = 1'($urandom);
        target_a = A_W'($urandom);
        branch_b = 1'($urandom);
        target_b = B_W'($urandom);
        #2 reset = 1'b0;
        #1;
        check("rand_async_a", int'(pc_a), 0);
        check("rand_async_b", int'(pc_b), 0);
        @(negedge clk);
        reset = 1'b1;
      end else begin
        branch_a = ($urandom_range(0, 3) == 0);
        target_a = A_W'($urandom);
        branch_b = ($urandom_range(0, 3) == 0);
        target_b = B_W'($urandom);
        @(negedge clk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
